// File: rtl/stopwatch_counter.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_counter
// Purpose  : Time-keeping core of the stopwatch. Counts 10 ms ticks as BCD
//            MM:SS.CC, controlled by start/stop, clear and (optionally) lap
//            pulses. It feeds six BCD digits to the display multiplexer.
// Ports    : clk         - system clock, single domain
//            reset       - synchronous, active-high
//            tick_10ms   - one-cycle 10 ms pulse from the clock divider
//            start_stop  - one-cycle pulse, start/pause toggle
//            clear       - one-cycle pulse, zero the count (PAUSE/DONE only)
//            lap         - one-cycle pulse, freeze/unfreeze the display
//            disp_bcd    - {min_t,min_o,sec_t,sec_o,cs_t,cs_o}, BCD digits
//            running     - high while in RUN
//            lap_active  - high while the display is frozen
//            overflow    - SATURATE=1: level in DONE; SATURATE=0: wrap pulse
// Params   : MAX_MIN  (1..99) highest minute; the limit is MAX_MIN:59.99
//            SATURATE 1: hold at the limit and enter DONE; 0: wrap to zero
// Options  : STOPWATCH_LAP_EN - builds the lap snapshot register and logic.
//            When undefined, lap is ignored and lap_active is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_counter #(
  parameter int unsigned MAX_MIN  = 99,
  parameter bit          SATURATE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_10ms,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        lap,
  output logic [23:0] disp_bcd,
  output logic        running,
  output logic        lap_active,
  output logic        overflow
);

  // Minute limit split into BCD digits at elaboration time; the running
  // count itself is only ever manipulated digit by digit.
  localparam logic [3:0] MAX_MIN_T = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_MIN_O = 4'(MAX_MIN % 10);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // Live count digits
  logic [3:0] min_t;
  logic [3:0] min_o;
  logic [3:0] sec_t;
  logic [3:0] sec_o;
  logic [3:0] cs_t;
  logic [3:0] cs_o;

  // Next-count digits from the increment cascade
  logic [3:0] inc_min_t;
  logic [3:0] inc_min_o;
  logic [3:0] inc_sec_t;
  logic [3:0] inc_sec_o;
  logic [3:0] inc_cs_t;
  logic [3:0] inc_cs_o;

  logic [23:0] live_bcd;
  logic [23:0] nxt_bcd;

  logic count_en;
  logic at_limit;
  logic hit_limit;
  logic wrap;
  logic count_clr;
  logic lap_req;

  // Carry chain: each flag means "this digit and everything below it are at
  // their maximum", so the next digit up advances on this tick.
  logic carry_cs_t;
  logic carry_sec_o;
  logic carry_sec_t;
  logic carry_min_o;
  logic carry_min_t;

  assign live_bcd = {min_t, min_o, sec_t, sec_o, cs_t, cs_o};

  assign count_en = (state == RUN) && tick_10ms;

  assign carry_cs_t  = (cs_o == 4'd9);
  assign carry_sec_o = carry_cs_t  && (cs_t  == 4'd9);
  assign carry_sec_t = carry_sec_o && (sec_o == 4'd9);
  assign carry_min_o = carry_sec_t && (sec_t == 4'd5);
  assign carry_min_t = carry_min_o && (min_o == 4'd9);

  assign at_limit = (min_t == MAX_MIN_T) && (min_o == MAX_MIN_O) &&
                    (sec_t == 4'd5) && (sec_o == 4'd9) &&
                    (cs_t  == 4'd9) && (cs_o  == 4'd9);

  // --------------------------------------------------------------------------
  // Digit cascade and limit handling
  // --------------------------------------------------------------------------
  always_comb begin : count_next
    inc_min_t = min_t;
    inc_min_o = min_o;
    inc_sec_t = sec_t;
    inc_sec_o = sec_o;
    inc_cs_t  = cs_t;
    inc_cs_o  = cs_o;
    hit_limit = 1'b0;
    wrap      = 1'b0;

    if (count_en) begin
      if (at_limit) begin
        hit_limit = 1'b1;
        // Saturating build keeps the digits; the FSM moves to DONE.
        if (!SATURATE) begin
          inc_min_t = 4'd0;
          inc_min_o = 4'd0;
          inc_sec_t = 4'd0;
          inc_sec_o = 4'd0;
          inc_cs_t  = 4'd0;
          inc_cs_o  = 4'd0;
          wrap      = 1'b1;
        end
      end else begin
        inc_cs_o = carry_cs_t ? 4'd0 : cs_o + 4'd1;
        if (carry_cs_t) begin
          inc_cs_t = (cs_t == 4'd9) ? 4'd0 : cs_t + 4'd1;
        end
        if (carry_sec_o) begin
          inc_sec_o = (sec_o == 4'd9) ? 4'd0 : sec_o + 4'd1;
        end
        if (carry_sec_t) begin
          inc_sec_t = (sec_t == 4'd5) ? 4'd0 : sec_t + 4'd1;
        end
        // Minutes never pass MAX_MIN because the limit check above wins,
        // so the tens digit needs no upper-bound test of its own.
        if (carry_min_o) begin
          inc_min_o = (min_o == 4'd9) ? 4'd0 : min_o + 4'd1;
        end
        if (carry_min_t) begin
          inc_min_t = min_t + 4'd1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // State machine: next state and control strobes
  // --------------------------------------------------------------------------
  always_comb begin : fsm_next
    state_nxt = state;
    count_clr = 1'b0;

    case (state)
      IDLE: begin
        // clear outranks start_stop, and clear in IDLE is a no-op, so a
        // simultaneous clear+start_stop leaves the watch idle.
        if (!clear && start_stop) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        // clear is ignored while running. Reaching the limit wins over a
        // coincident start_stop in the saturating build.
        if (SATURATE && hit_limit) begin
          state_nxt = DONE;
        end else if (start_stop) begin
          state_nxt = PAUSE;
        end
      end
      PAUSE: begin
        if (clear) begin
          state_nxt = IDLE;
          count_clr = 1'b1;
        end else if (start_stop) begin
          state_nxt = RUN;
        end
      end
      DONE: begin
        if (clear) begin
          state_nxt = IDLE;
          count_clr = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        count_clr = 1'b1;
      end
    endcase
  end

  assign nxt_bcd = count_clr ? 24'h000000
                             : {inc_min_t, inc_min_o, inc_sec_t,
                                inc_sec_o, inc_cs_t,  inc_cs_o};

  // Lap toggles only in RUN or PAUSE, and a clear accepted in PAUSE takes
  // precedence since it sends the watch back to IDLE.
  assign lap_req = lap && ((state == RUN) || ((state == PAUSE) && !clear));

  // --------------------------------------------------------------------------
  // State, count and status registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      min_t    <= 4'd0;
      min_o    <= 4'd0;
      sec_t    <= 4'd0;
      sec_o    <= 4'd0;
      cs_t     <= 4'd0;
      cs_o     <= 4'd0;
      running  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      {min_t, min_o, sec_t, sec_o, cs_t, cs_o} <= nxt_bcd;
      running <= (state_nxt == RUN);
      // Level in DONE for the saturating build; single-cycle pulse on wrap
      // otherwise (DONE is unreachable when SATURATE=0).
      overflow <= SATURATE ? (state_nxt == DONE) : wrap;
    end
  end

`ifdef STOPWATCH_LAP_EN
  // --------------------------------------------------------------------------
  // Lap snapshot: freezes the display while counting continues underneath.
  // --------------------------------------------------------------------------
  logic [23:0] snapshot;
  logic        lap_on;

  always_ff @(posedge clk) begin
    if (reset) begin
      lap_on   <= 1'b0;
      snapshot <= 24'h000000;
    end else begin
      if (count_clr) begin
        lap_on <= 1'b0;
      end else if (lap_req) begin
        lap_on <= !lap_on;
        // Capture the post-tick value so a tick landing with the lap
        // press is included in the frozen reading.
        if (!lap_on) begin
          snapshot <= nxt_bcd;
        end
      end
    end
  end

  assign lap_active = lap_on;
  assign disp_bcd   = lap_on ? snapshot : live_bcd;
`else
  // Lap feature not built: the input is intentionally left unused.
  logic unused_lap;
  assign unused_lap = lap_req;
  assign lap_active = 1'b0;
  assign disp_bcd   = live_bcd;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_counter
// Purpose  : Scoreboard bench for stopwatch_counter. Two instances share one
//            input stream: MAX_MIN=1 saturating and MAX_MIN=1 wrapping. A
//            reference model tracks elapsed time as a plain centisecond
//            count; expected outputs are queued per cycle and a monitor pops
//            and compares them after each clock edge. Selected cycles also
//            carry fixed expected readings taken from the stopwatch rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        tick_10ms;
  logic        start_stop;
  logic        clear;
  logic        lap;
  logic [23:0] disp_s;
  logic [23:0] disp_w;
  logic        run_s;
  logic        run_w;
  logic        lap_s;
  logic        lap_w;
  logic        ovf_s;
  logic        ovf_w;

  stopwatch_counter #(.MAX_MIN(1), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .reset(reset), .tick_10ms(tick_10ms), .start_stop(start_stop),
    .clear(clear), .lap(lap), .disp_bcd(disp_s), .running(run_s),
    .lap_active(lap_s), .overflow(ovf_s)
  );

  stopwatch_counter #(.MAX_MIN(1), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .reset(reset), .tick_10ms(tick_10ms), .start_stop(start_stop),
    .clear(clear), .lap(lap), .disp_bcd(disp_w), .running(run_w),
    .lap_active(lap_w), .overflow(ovf_w)
  );

  localparam int ST_IDLE  = 0;
  localparam int ST_RUN   = 1;
  localparam int ST_PAUSE = 2;
  localparam int ST_DONE  = 3;

  typedef struct {
    int st;
    int cnt;
    int snap;
    bit lapa;
    bit ovf;
  } mdl_t;

  typedef struct {
    logic [26:0] exp;
    bit          has_k;
    logic [26:0] k;
    int          name_idx;
  } sb_t;

  int    tests = 0;
  int    fails = 0;
  sb_t   q_sat[$];
  sb_t   q_wrap[$];
  string knames[$];
  mdl_t  m_sat  = '{0, 0, 0, 1'b0, 1'b0};
  mdl_t  m_wrap = '{0, 0, 0, 1'b0, 1'b0};

  bit          k_set = 1'b0;
  logic [26:0] k_sat;
  logic [26:0] k_wrap;
  string       k_name;

  // Elapsed centiseconds rendered as MM:SS.CC BCD.
  function automatic logic [23:0] to_bcd(int cs);
    int mins;
    int secs;
    int c;
    mins = cs / 6000;
    secs = (cs / 100) % 60;
    c    = cs % 100;
    return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10),
            4'(c / 10), 4'(c % 10)};
  endfunction

  function automatic logic [26:0] outs(mdl_t m);
    return {to_bcd(m.lapa ? m.snap : m.cnt), (m.st == ST_RUN), m.lapa, m.ovf};
  endfunction

  function automatic logic [26:0] kv(logic [23:0] d, bit r, bit l, bit o);
    return {d, r, l, o};
  endfunction

  // One clock of stopwatch behaviour.
  function automatic mdl_t step(mdl_t m, int max_min, bit sat, bit rst,
                                bit tk, bit ss, bit clr, bit lp);
    mdl_t n;
    int   limit;
    n     = m;
    n.ovf = 1'b0;
    limit = max_min * 6000 + 5999;
    if (rst) begin
      n = '{ST_IDLE, 0, 0, 1'b0, 1'b0};
      return n;
    end
    if (m.st == ST_RUN && tk) begin
      if (m.cnt == limit) begin
        if (sat) begin
          n.st = ST_DONE;
        end else begin
          n.cnt = 0;
          n.ovf = 1'b1;
        end
      end else begin
        n.cnt = m.cnt + 1;
      end
    end
    case (m.st)
      ST_IDLE:  if (!clr && ss) n.st = ST_RUN;
      ST_RUN:   if (ss && n.st != ST_DONE) n.st = ST_PAUSE;
      ST_PAUSE: begin
        if (clr) begin
          n.st = ST_IDLE; n.cnt = 0; n.lapa = 1'b0;
        end else if (ss) begin
          n.st = ST_RUN;
        end
      end
      default: begin
        if (clr) begin
          n.st = ST_IDLE; n.cnt = 0; n.lapa = 1'b0;
        end
      end
    endcase
`ifdef STOPWATCH_LAP_EN
    if (lp && (m.st == ST_RUN || (m.st == ST_PAUSE && !clr))) begin
      n.lapa = !m.lapa;
      if (n.lapa) n.snap = n.cnt;
    end
`else
    if (lp) n.lapa = 1'b0;
`endif
    if (sat) n.ovf = (n.st == ST_DONE);
    return n;
  endfunction

  // Drive one cycle of inputs and queue the expected result after the edge.
  task automatic cyc(input bit rst, input bit tk, input bit ss,
                     input bit clr, input bit lp);
    sb_t e;
    @(negedge clk);
    reset      = rst;
    tick_10ms  = tk;
    start_stop = ss;
    clear      = clr;
    lap        = lp;
    m_sat  = step(m_sat,  1, 1'b1, rst, tk, ss, clr, lp);
    m_wrap = step(m_wrap, 1, 1'b0, rst, tk, ss, clr, lp);
    knames.push_back(k_set ? k_name : "model");
    e.name_idx = knames.size() - 1;
    e.has_k    = k_set;
    e.exp      = outs(m_sat);
    e.k        = k_sat;
    q_sat.push_back(e);
    e.exp      = outs(m_wrap);
    e.k        = k_wrap;
    q_wrap.push_back(e);
    k_set = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Attach fixed expected readings to the next cycle driven.
  task automatic expect_k(input string nm, input logic [26:0] ks,
                          input logic [26:0] kw);
    k_set  = 1'b1;
    k_name = nm;
    k_sat  = ks;
    k_wrap = kw;
  endtask

  task automatic check(input string who, input sb_t e, input logic [26:0] act);
    tests++;
    if (act !== e.exp) begin
      fails++;
      $display("FAIL %s/%s model @%0t: got disp=%h run=%b lap=%b ovf=%b, want disp=%h run=%b lap=%b ovf=%b",
               who, knames[e.name_idx], $time, act[26:3], act[2], act[1], act[0],
               e.exp[26:3], e.exp[2], e.exp[1], e.exp[0]);
    end
    if (e.has_k) begin
      tests++;
      if (act !== e.k) begin
        fails++;
        $display("FAIL %s/%s @%0t: got disp=%h run=%b lap=%b ovf=%b, want disp=%h run=%b lap=%b ovf=%b",
                 who, knames[e.name_idx], $time, act[26:3], act[2], act[1], act[0],
                 e.k[26:3], e.k[2], e.k[1], e.k[0]);
      end
    end
  endtask

  // Monitor: outputs are presented every cycle, sampled just after the edge.
  initial begin : monitor
    sb_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q_sat.size() > 0) begin
        e = q_sat.pop_front();
        check("sat", e, {disp_s, run_s, lap_s, ovf_s});
      end
      if (q_wrap.size() > 0) begin
        e = q_wrap.pop_front();
        check("wrap", e, {disp_w, run_w, lap_w, ovf_w});
      end
    end
  end

  initial begin : stimulus
    int  r;
    bit  tk;
    bit  ss;
    bit  clr;
    bit  lp;
    bit  rst;
    int  wait_cycles;
    reset = 1'b1; tick_10ms = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;

    // Reset state
    cyc(1, 0, 0, 0, 0);
    expect_k("reset_state", kv(24'h000000, 0, 0, 0), kv(24'h000000, 0, 0, 0));
    cyc(1, 0, 0, 0, 0);

    // Reset while running at 00:03.47, with a tick in the same cycle
    cyc(0, 0, 1, 0, 0);
    ticks(346);
    expect_k("run_0347", kv(24'h000347, 1, 0, 0), kv(24'h000347, 1, 0, 0));
    ticks(1);
    expect_k("reset_mid_run", kv(24'h000000, 0, 0, 0), kv(24'h000000, 0, 0, 0));
    cyc(1, 1, 0, 0, 0);

    // 100 ticks then stop; ticks while paused are dropped
    cyc(0, 0, 1, 0, 0);
    ticks(100);
    expect_k("stop_at_0100", kv(24'h000100, 0, 0, 0), kv(24'h000100, 0, 0, 0));
    cyc(0, 0, 1, 0, 0);
    ticks(4);
    expect_k("pause_drops_ticks", kv(24'h000100, 0, 0, 0), kv(24'h000100, 0, 0, 0));
    ticks(1);
    cyc(0, 0, 0, 1, 0);

    // Carries: 00:59.99 -> 01:00.00 and 00:09.99 -> 00:10.00
    cyc(0, 0, 1, 0, 0);
    ticks(5998);
    expect_k("at_0059_99", kv(24'h005999, 1, 0, 0), kv(24'h005999, 1, 0, 0));
    ticks(1);
    expect_k("minute_carry", kv(24'h010000, 1, 0, 0), kv(24'h010000, 1, 0, 0));
    ticks(1);
    cyc(0, 0, 1, 0, 0);
    expect_k("clear_from_pause", kv(24'h000000, 0, 0, 0), kv(24'h000000, 0, 0, 0));
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 0);
    ticks(998);
    expect_k("at_0009_99", kv(24'h000999, 1, 0, 0), kv(24'h000999, 1, 0, 0));
    ticks(1);
    expect_k("ten_sec_carry", kv(24'h001000, 1, 0, 0), kv(24'h001000, 1, 0, 0));
    ticks(1);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0);

    // Same-cycle interactions
    cyc(0, 0, 1, 0, 0);
    ticks(5);
    expect_k("tick_and_stop", kv(24'h000006, 0, 0, 0), kv(24'h000006, 0, 0, 0));
    cyc(0, 1, 1, 0, 0);
    expect_k("clear_beats_start", kv(24'h000000, 0, 0, 0), kv(24'h000000, 0, 0, 0));
    cyc(0, 0, 1, 1, 0);
    expect_k("idle_tick_not_counted", kv(24'h000000, 1, 0, 0), kv(24'h000000, 1, 0, 0));
    cyc(0, 1, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0);

    // Limit 01:59.99: saturate vs wrap
    cyc(0, 0, 1, 0, 0);
    ticks(11998);
    expect_k("at_limit", kv(24'h015999, 1, 0, 0), kv(24'h015999, 1, 0, 0));
    ticks(1);
    expect_k("limit_tick", kv(24'h015999, 0, 0, 1), kv(24'h000000, 1, 0, 1));
    ticks(1);
    expect_k("after_limit", kv(24'h015999, 0, 0, 1), kv(24'h000001, 1, 0, 0));
    ticks(1);
    expect_k("done_ignores_start", kv(24'h015999, 0, 0, 1), kv(24'h000001, 0, 0, 0));
    cyc(0, 0, 1, 0, 0);
    expect_k("clear_from_done", kv(24'h000000, 0, 0, 0), kv(24'h000000, 0, 0, 0));
    cyc(0, 0, 0, 1, 0);

`ifdef STOPWATCH_LAP_EN
    // Lap freeze / release
    cyc(0, 0, 1, 0, 0);
    ticks(250);
    expect_k("lap_freeze", kv(24'h000250, 1, 1, 0), kv(24'h000250, 1, 1, 0));
    cyc(0, 0, 0, 0, 1);
    ticks(29);
    expect_k("lap_held", kv(24'h000250, 1, 1, 0), kv(24'h000250, 1, 1, 0));
    ticks(1);
    expect_k("lap_release", kv(24'h000280, 1, 0, 0), kv(24'h000280, 1, 0, 0));
    cyc(0, 0, 0, 0, 1);
    expect_k("lap_with_tick", kv(24'h000281, 1, 1, 0), kv(24'h000281, 1, 1, 0));
    cyc(0, 1, 0, 0, 1);
    cyc(0, 0, 1, 0, 0);
    expect_k("clear_drops_lap", kv(24'h000000, 0, 0, 0), kv(24'h000000, 0, 0, 0));
    cyc(0, 0, 0, 1, 0);
`else
    expect_k("lap_ignored", kv(24'h000000, 0, 0, 0), kv(24'h000000, 0, 0, 0));
    cyc(0, 0, 0, 0, 1);
`endif

    // Randomized traffic against the model (clear is kept out of RUN)
    for (int i = 0; i < 4000; i++) begin
      tk  = bit'($urandom_range(0, 1));
      r   = int'($urandom_range(0, 199));
      ss  = (r < 8);
      clr = (r >= 4 && r < 14) && (m_sat.st != ST_RUN) && (m_wrap.st != ST_RUN);
      lp  = (r >= 14 && r < 24);
      rst = (r == 199);
      cyc(rst, tk, ss, clr, lp);
    end
    cyc(0, 0, 0, 0, 0);

    // Drain the scoreboard with a bounded wait
    wait_cycles = 0;
    while ((q_sat.size() > 0 || q_wrap.size() > 0) && wait_cycles < 10) begin
      @(posedge clk);
      #2;
      wait_cycles++;
    end
    tests++;
    if (q_sat.size() > 0 || q_wrap.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d/%0d entries left, want 0", q_sat.size(), q_wrap.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
